// File: rtl/pio_pkg.sv
// Shared register-map and edge-select constants for the bidirectional PIO.
package pio_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA    = 3'd0,
    ADDR_DIR     = 3'd1,
    ADDR_IRQMASK = 3'd2,
    ADDR_EDGECAP = 3'd3,
    ADDR_OUTSET  = 3'd4,
    ADDR_OUTCLR  = 3'd5,
    ADDR_RSVD6   = 3'd6,
    ADDR_RSVD7   = 3'd7
  } pio_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Pad input synchroniser, one-cycle history and edge vector, masked during the
// post-reset warm-up window so pads already high at reset give no false edge.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] sync_in_o,
  output logic [WIDTH-1:0] edge_o
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] WARM_DONE = CNT_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [CNT_W-1:0] warm_q, warm_d;
  logic [WIDTH-1:0] rise, fall, raw_edge;

  // NOTE: sequential state uses non-blocking assignments only; the chain shift
  // relies on every stage sampling its predecessor's pre-edge value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      warm_q <= '0;
    end else begin
      sync_q[0] <= pad_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      warm_q <= warm_d;
    end
  end

  assign sync_in_o = sync_q[SYNC_STAGES-1];

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    warm_d   = (warm_q == WARM_DONE) ? warm_q : warm_q + 1'b1;
    rise     = sync_in_o & ~prev_q;
    fall     = ~sync_in_o & prev_q;
    raw_edge = rise | fall;
    if (EDGE_TYPE == EDGE_RISE)      raw_edge = rise;
    else if (EDGE_TYPE == EDGE_FALL) raw_edge = fall;
    edge_o = (warm_q == WARM_DONE) ? raw_edge : '0;
  end

endmodule

// File: rtl/avalon_bidir_pio.sv
// Avalon-MM bidirectional PIO: per-bit direction, atomic set/clear of the
// output register, edge capture with IRQ mask and a level interrupt.
module avalon_bidir_pio
  import pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] bidir_port
);

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] sync_in, edge_vec, clr, wdata, rd_val;
  logic             wr_en;
  logic             unused_wdata;

  pio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .pad_i    (bidir_port),
    .sync_in_o(sync_in),
    .edge_o   (edge_vec)
  );

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irqmask_d  = irqmask_q;
    clr        = '0;
    if (wr_en) begin
      case (pio_addr_e'(address))
        ADDR_DATA:    data_out_d = wdata;
        ADDR_DIR:     dir_d      = wdata;
        ADDR_IRQMASK: irqmask_d  = wdata;
        ADDR_EDGECAP: clr        = wdata;
        ADDR_OUTSET:  data_out_d = data_out_q | wdata;
        ADDR_OUTCLR:  data_out_d = data_out_q & ~wdata;
        default:      ;
      endcase
    end
    // A new edge in the same cycle as its clear keeps the bit set.
    edgecap_d = edge_vec | (edgecap_q & ~clr);

    rd_val = '0;
    case (pio_addr_e'(address))
      ADDR_DATA:    rd_val = sync_in;
      ADDR_DIR:     rd_val = dir_q;
      ADDR_IRQMASK: rd_val = irqmask_q;
      ADDR_EDGECAP: rd_val = edgecap_q;
      default:      rd_val = '0;
    endcase
    readdata_d = 32'(rd_val);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out_q <= RESET_OUT;
      dir_q      <= RESET_DIR;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

  for (genvar g = 0; g < WIDTH; g++) begin : g_pad
    assign bidir_port[g] = dir_q[g] ? data_out_q[g] : 1'bz;
  end

endmodule

// File: tb/tb_avalon_bidir_pio.sv
// Directed self-checking bench for avalon_bidir_pio (WIDTH=8, rising edges,
// two-stage synchroniser, RESET_DIR=8'h0F, RESET_OUT=8'h05).
module tb_avalon_bidir_pio;
  import pio_pkg::*;

  localparam int W  = 8;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  wire  [31:0] readdata;
  wire         irq;
  wire  [W-1:0] pads;
  logic [W-1:0] tb_oe, tb_val;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [31:0] exp_rd;
    logic [7:0]  exp_pads;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < W; g++) begin : g_drv
    assign pads[g] = tb_oe[g] ? tb_val[g] : 1'bz;
  end

  avalon_bidir_pio #(
    .WIDTH      (W),
    .EDGE_TYPE  (EDGE_RISE),
    .SYNC_STAGES(SS),
    .RESET_DIR  (8'h0F),
    .RESET_OUT  (8'h05)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .bidir_port(pads)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;

    vecs[0] = '{ADDR_IRQMASK, 32'hFFFF_FF5A, ADDR_IRQMASK, 32'h0000_005A, 8'h23};
    vecs[1] = '{ADDR_DIR,     32'h0000_01FF, ADDR_DIR,     32'h0000_00FF, 8'h23};
    vecs[2] = '{ADDR_OUTSET,  32'h0000_000C, ADDR_OUTSET,  32'h0000_0000, 8'h2F};
    vecs[3] = '{ADDR_OUTCLR,  32'h0000_0021, ADDR_OUTCLR,  32'h0000_0000, 8'h0E};
    vecs[4] = '{ADDR_RSVD6,   32'hFFFF_FFFF, ADDR_RSVD6,   32'h0000_0000, 8'h0E};
    vecs[5] = '{ADDR_RSVD7,   32'hFFFF_FFFF, ADDR_RSVD7,   32'h0000_0000, 8'h0E};
    vecs[6] = '{ADDR_DATA,    32'h0000_01C3, ADDR_DIR,     32'h0000_00FF, 8'hC3};
    vecs[7] = '{ADDR_IRQMASK, 32'h0000_0000, ADDR_IRQMASK, 32'h0000_0000, 8'hC3};

    // Reset state: low nibble driven from RESET_OUT, high nibble is input.
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 3'd0; writedata = '0;
    tb_oe = 8'hF0; tb_val = 8'hA0;
    cycles(3);
    check("reset readdata", readdata, 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    check("reset pads[3:0]", 32'(pads[3:0]), 32'h5);
    @(negedge clk);
    reset_n = 1'b1; address = ADDR_EDGECAP;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("warmup1 edgecap", readdata, 32'h0);
    end
    rd(ADDR_DIR, d);  check("reset DIR", d, 32'h0000_000F);
    rd(ADDR_DATA, d); check("reset DATA readback", d, 32'h0000_00A5);

    // Output path with atomic set/clear.
    @(negedge clk); tb_oe = 8'h00;
    wr(ADDR_DIR, 32'hFF);
    wr(ADDR_DATA, 32'hA0);
    wr(ADDR_OUTSET, 32'h03);
    wr(ADDR_OUTCLR, 32'h80);
    check("pads after set/clr", 32'(pads), 32'h23);
    cycles(SS + 2);
    rd(ADDR_DATA, d); check("DATA readback 0x23", d, 32'h23);

    // Register map table.
    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].waddr, vecs[i].wdata);
      check($sformatf("vec%0d pads", i), 32'(pads), 32'(vecs[i].exp_pads));
      rd(vecs[i].raddr, d);
      check($sformatf("vec%0d read", i), d, vecs[i].exp_rd);
    end

    // Rising-edge capture, irq, write-1-to-clear, falling edge ignored.
    wr(ADDR_DIR, 32'h00);
    tb_oe = 8'hFF; tb_val = 8'h5A;
    cycles(4);
    rd(ADDR_DATA, d); check("input DATA 0x5A", d, 32'h5A);
    tb_val = 8'h00;
    cycles(4);
    wr(ADDR_EDGECAP, 32'hFF);
    wr(ADDR_IRQMASK, 32'h04);
    rd(ADDR_EDGECAP, d); check("edgecap cleared", d, 32'h0);
    check("irq idle", 32'(irq), 32'h0);
    @(negedge clk); tb_val[2] = 1'b1;
    cycles(5);
    rd(ADDR_EDGECAP, d); check("edgecap rise bit2", d, 32'h04);
    check("irq on rise", 32'(irq), 32'h1);
    wr(ADDR_EDGECAP, 32'h04);
    check("irq after clear", 32'(irq), 32'h0);
    rd(ADDR_EDGECAP, d); check("edgecap after clear", d, 32'h0);
    @(negedge clk); tb_val[2] = 1'b0;
    cycles(5);
    rd(ADDR_EDGECAP, d); check("no capture on fall", d, 32'h0);

    // Edge detected in the same cycle as its clear: set wins.
    @(negedge clk); tb_val[2] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    wr(ADDR_EDGECAP, 32'h04);
    rd(ADDR_EDGECAP, d); check("set wins over clear", d, 32'h04);
    check("irq set wins", 32'(irq), 32'h1);
    wr(ADDR_EDGECAP, 32'h04);
    rd(ADDR_EDGECAP, d); check("edgecap cleared again", d, 32'h0);

    // Pads high through reset release give no false edge.
    @(negedge clk); reset_n = 1'b0; tb_oe = 8'hF0; tb_val = 8'hF0;
    cycles(2);
    check("reset2 readdata", readdata, 32'h0);
    check("reset2 irq", 32'(irq), 32'h0);
    check("reset2 pads[3:0]", 32'(pads[3:0]), 32'h5);
    @(negedge clk); reset_n = 1'b1; address = ADDR_EDGECAP;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("warmup2 edgecap", readdata, 32'h0);
    end
    wr(ADDR_OUTCLR, 32'h01);
    cycles(4);
    rd(ADDR_EDGECAP, d); check("pad0 fall ignored", d, 32'h0);
    wr(ADDR_OUTSET, 32'h01);
    cycles(4);
    rd(ADDR_EDGECAP, d); check("pad0 rise captured", d, 32'h01);

    // One-cycle reset mid-operation with everything set.
    @(negedge clk); tb_oe = 8'h00;
    wr(ADDR_DIR, 32'hFF);
    wr(ADDR_OUTCLR, 32'hFF);
    cycles(4);
    wr(ADDR_OUTSET, 32'hFF);
    cycles(4);
    wr(ADDR_IRQMASK, 32'hFF);
    rd(ADDR_EDGECAP, d); check("edgecap all set", d, 32'hFF);
    check("irq all set", 32'(irq), 32'h1);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1; tb_oe = 8'hF0; tb_val = 8'hF0; address = ADDR_EDGECAP;
    check("midreset irq", 32'(irq), 32'h0);
    check("midreset readdata", readdata, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("warmup3 edgecap", readdata, 32'h0);
    end
    rd(ADDR_DIR, d);     check("midreset DIR", d, 32'h0000_000F);
    rd(ADDR_IRQMASK, d); check("midreset IRQMASK", d, 32'h0);
    check("midreset pads[3:0]", 32'(pads[3:0]), 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
